// File: rtl/score_overlay_if.sv
// Score overlay bundle: add handshake, live score and the pixel pipeline in/out.
// The DUT takes the slave view; the pixel source / score producer takes master.
interface score_overlay_if #(
    parameter int DIGITS = 4
);
    logic                  ce;
    logic [9:0]            x;
    logic [9:0]            y;
    logic                  add_valid;
    logic [7:0]            add_pts;
    logic                  add_ready;
    logic                  clear;
    logic [4*DIGITS-1:0]   score_bcd;
    logic                  score_sat;
    logic                  pix_hit;
    logic [11:0]           pix_colour;

    modport master (
        output ce, x, y, add_valid, add_pts, clear,
        input  add_ready, score_bcd, score_sat, pix_hit, pix_colour
    );

    modport slave (
        input  ce, x, y, add_valid, add_pts, clear,
        output add_ready, score_bcd, score_sat, pix_hit, pix_colour
    );
endinterface

// File: rtl/score_overlay.sv
// BCD score counter with a 7-segment pixel overlay; SCORE_OVERLAY_LZ_BLANK_EN blanks leading zeros.
// Latency: pixel colour/hit valid after 2 ce cycles; score counts one point per clk.
// Backpressure: add_ready low while an addition is counting out or clear is asserted.
module score_overlay #(
    parameter int          DIGITS      = 4,
    parameter int          ORIGIN_X    = 50,
    parameter int          ORIGIN_Y    = 139,
    parameter int          DIGIT_PITCH = 25,
    parameter logic [11:0] FG          = 12'hFFF,
    parameter logic [11:0] BG          = 12'h000
) (
    input  logic           clk,
    input  logic           reset,
    score_overlay_if.slave bus
);
    localparam int SW = 4 * DIGITS;
    localparam logic [SW-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic {IDLE, COUNT} state_t;

    // Segment bits: [0]=a [1]=b [2]=c [3]=d [4]=e [5]=f [6]=g
    typedef struct packed {
        logic       in_cell;
        logic [2:0] idx;
        logic [6:0] seg;
    } px_t;

    state_t        state_q, state_d;
    logic [7:0]    rem_q, rem_d;
    logic [SW-1:0] score_q, score_d;
    logic [SW-1:0] snap_q, snap_d;
    px_t           px_q, px_d, px_calc;
    logic          hit_q, hit_d;
    logic [11:0]   colour_q, colour_d;

    logic          add_ready;
    logic          score_sat;
    logic [31:0]   xi, yi, rx, ry;
    logic [3:0]    cell_digit;
    logic          lit;

    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    assign score_sat = (score_q == ALL_NINES);

    // Adder FSM: clear overrides everything, including a coincident add request.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        score_d   = score_q;
        add_ready = (state_q == IDLE) && !bus.clear;
        if (bus.clear) begin
            score_d = '0;
            rem_d   = '0;
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (bus.add_valid) begin
                rem_d   = bus.add_pts;
                state_d = (bus.add_pts != 8'd0) ? COUNT : IDLE;
            end
        end else begin
            if (!score_sat) begin
                score_d = bcd_inc(score_q);
            end
            rem_d = rem_q - 8'd1;
            if (rem_q == 8'd1) begin
                state_d = IDLE;
            end
        end
    end

    // Stage 1: locate the cell (lowest k wins) and the geometric segment band.
    always_comb begin
        px_calc = '0;
        xi      = {22'd0, bus.x};
        yi      = {22'd0, bus.y};
        ry      = yi - 32'(ORIGIN_Y);
        rx      = '0;
        if (yi >= 32'(ORIGIN_Y) && ry <= 32'd34) begin
            for (int k = DIGITS - 1; k >= 0; k--) begin
                if (xi >= 32'(ORIGIN_X + k * DIGIT_PITCH) &&
                    (xi - 32'(ORIGIN_X + k * DIGIT_PITCH)) <= 32'd19) begin
                    px_calc.in_cell = 1'b1;
                    px_calc.idx     = 3'(k);
                    rx              = xi - 32'(ORIGIN_X + k * DIGIT_PITCH);
                end
            end
        end
        if (px_calc.in_cell) begin
            if (ry <= 32'd6) begin
                px_calc.seg[0] = 1'b1;
            end else if (ry <= 32'd13) begin
                px_calc.seg[5] = (rx <= 32'd4);
                px_calc.seg[1] = (rx >= 32'd15);
            end else if (ry <= 32'd20) begin
                px_calc.seg[6] = 1'b1;
            end else if (ry <= 32'd27) begin
                px_calc.seg[4] = (rx <= 32'd4);
                px_calc.seg[2] = (rx >= 32'd15);
            end else begin
                px_calc.seg[3] = 1'b1;
            end
        end
    end

`ifdef SCORE_OVERLAY_LZ_BLANK_EN
    logic [7:0] blank;
    logic       lead;

    // A position is blank while every more-significant snapshot digit is also zero.
    always_comb begin
        blank = '0;
        lead  = 1'b1;
        for (int k = 0; k < DIGITS - 1; k++) begin
            lead     = lead && (snap_q[4*(DIGITS-1-k) +: 4] == 4'd0);
            blank[k] = lead;
        end
    end
`endif

    // Stage 2: the leftmost cell shows the most-significant snapshot digit.
    always_comb begin
        cell_digit = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (px_q.idx == 3'(k)) begin
                cell_digit = snap_q[4*(DIGITS-1-k) +: 4];
            end
        end
        lit = |(px_q.seg & seg_decode(cell_digit));
`ifdef SCORE_OVERLAY_LZ_BLANK_EN
        if (blank[px_q.idx]) begin
            lit = 1'b0;
        end
`endif
        px_d     = bus.ce ? px_calc : px_q;
        hit_d    = bus.ce ? px_q.in_cell : hit_q;
        colour_d = bus.ce ? (lit ? FG : BG) : colour_q;
        snap_d   = (bus.ce && bus.x == 10'd0 && bus.y == 10'd0) ? score_q : snap_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            score_q  <= '0;
            snap_q   <= '0;
            px_q     <= '0;
            hit_q    <= 1'b0;
            colour_q <= BG;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            score_q  <= score_d;
            snap_q   <= snap_d;
            px_q     <= px_d;
            hit_q    <= hit_d;
            colour_q <= colour_d;
        end
    end

    assign bus.add_ready  = add_ready;
    assign bus.score_bcd  = score_q;
    assign bus.score_sat  = score_sat;
    assign bus.pix_hit    = hit_q;
    assign bus.pix_colour = colour_q;
endmodule

// File: tb/tb_score_overlay.sv
// Directed bench for score_overlay: adder handshake, saturation, clear, overlay rendering.
module tb_score_overlay;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    score_overlay_if #(.DIGITS(4)) bus();

    score_overlay #(
        .DIGITS(4), .ORIGIN_X(50), .ORIGIN_Y(139), .DIGIT_PITCH(25),
        .FG(12'hFFF), .BG(12'h000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

`ifdef SCORE_OVERLAY_LZ_BLANK_EN
    localparam logic [11:0] LZ_COL = 12'h000;
`else
    localparam logic [11:0] LZ_COL = 12'hFFF;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_add(input int n, output int low);
        int waited;
        waited = 0;
        while (!bus.add_ready && waited < 400) begin
            tick();
            waited++;
        end
        bus.add_valid = 1'b1;
        bus.add_pts   = n[7:0];
        tick();
        bus.add_valid = 1'b0;
        low = 0;
        while (!bus.add_ready && low < 400) begin
            tick();
            low++;
        end
    endtask

    task automatic clear_score();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic build_score(input int target);
        int remaining;
        int n;
        int low;
        clear_score();
        remaining = target;
        while (remaining > 0) begin
            n = (remaining > 250) ? 250 : remaining;
            do_add(n, low);
            remaining -= n;
        end
    endtask

    task automatic frame_start();
        bus.ce = 1'b1;
        bus.x  = 10'd0;
        bus.y  = 10'd0;
        tick();
        bus.ce = 1'b0;
    endtask

    task automatic render(input logic [9:0] px, input logic [9:0] py,
                          output logic hit, output logic [11:0] col);
        bus.ce = 1'b1;
        bus.x  = px;
        bus.y  = py;
        tick();
        bus.x  = 10'd1023;
        bus.y  = 10'd1023;
        tick();
        bus.ce = 1'b0;
        hit    = bus.pix_hit;
        col    = bus.pix_colour;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.ce = 1'b1; bus.x = 10'd5; bus.y = 10'd5;
        bus.add_valid = 1'b0; bus.add_pts = 8'd0; bus.clear = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.pix_hit !== 1'b0) begin
            errors++; $display("FAIL reset_pix_hit: got %0b want 0", bus.pix_hit);
        end
        checks++;
        if (bus.pix_colour !== 12'h000) begin
            errors++; $display("FAIL reset_pix_colour: got %h want 000", bus.pix_colour);
        end
        reset = 1'b0;
        bus.ce = 1'b0;
        checks++;
        if (bus.add_ready !== 1'b1) begin
            errors++; $display("FAIL reset_add_ready: got %0b want 1", bus.add_ready);
        end
        checks++;
        if (bus.score_bcd !== 16'h0000 || bus.score_sat !== 1'b0) begin
            errors++; $display("FAIL reset_score: got %h sat %0b want 0000 sat 0", bus.score_bcd, bus.score_sat);
        end
    endtask

    task automatic test_add37();
        int low;
        do_add(37, low);
        checks++;
        if (low !== 37) begin
            errors++; $display("FAIL add37_ready_low: got %0d cycles want 37", low);
        end
        checks++;
        if (bus.score_bcd !== 16'h0037) begin
            errors++; $display("FAIL add37_score: got %h want 0037", bus.score_bcd);
        end
    endtask

    task automatic test_saturate();
        int low;
        build_score(9995);
        checks++;
        if (bus.score_bcd !== 16'h9995 || bus.score_sat !== 1'b0) begin
            errors++; $display("FAIL sat_pre: got %h sat %0b want 9995 sat 0", bus.score_bcd, bus.score_sat);
        end
        do_add(10, low);
        checks++;
        if (low !== 10) begin
            errors++; $display("FAIL sat_ready_low: got %0d cycles want 10", low);
        end
        checks++;
        if (bus.score_bcd !== 16'h9999 || bus.score_sat !== 1'b1) begin
            errors++; $display("FAIL sat_score: got %h sat %0b want 9999 sat 1", bus.score_bcd, bus.score_sat);
        end
        do_add(5, low);
        checks++;
        if (bus.score_bcd !== 16'h9999) begin
            errors++; $display("FAIL sat_no_wrap: got %h want 9999", bus.score_bcd);
        end
    endtask

    task automatic test_clear();
        clear_score();
        bus.add_valid = 1'b1;
        bus.add_pts   = 8'd200;
        tick();
        bus.add_valid = 1'b0;
        repeat (5) tick();
        checks++;
        if (bus.score_bcd !== 16'h0005) begin
            errors++; $display("FAIL clear_midcount: got %h want 0005", bus.score_bcd);
        end
        bus.clear     = 1'b1;
        bus.add_valid = 1'b1;
        bus.add_pts   = 8'd9;
        #1;
        checks++;
        if (bus.add_ready !== 1'b0) begin
            errors++; $display("FAIL clear_ready_during: got %0b want 0", bus.add_ready);
        end
        tick();
        checks++;
        if (bus.score_bcd !== 16'h0000) begin
            errors++; $display("FAIL clear_score: got %h want 0000", bus.score_bcd);
        end
        bus.clear     = 1'b0;
        bus.add_valid = 1'b0;
        #1;
        checks++;
        if (bus.add_ready !== 1'b1) begin
            errors++; $display("FAIL clear_ready_after: got %0b want 1", bus.add_ready);
        end
        repeat (3) tick();
        checks++;
        if (bus.score_bcd !== 16'h0000) begin
            errors++; $display("FAIL clear_not_accepted: got %h want 0000", bus.score_bcd);
        end
    endtask

    task automatic test_pixels();
        logic        h;
        logic [11:0] c;
        build_score(8);
        frame_start();
        render(10'd60, 10'd145, h, c);
        checks++;
        if (h !== 1'b1 || c !== LZ_COL) begin
            errors++; $display("FAIL pix_msd_seg_a: got hit %0b col %h want hit 1 col %h", h, c, LZ_COL);
        end
        render(10'd60, 10'd156, h, c);
        checks++;
        if (h !== 1'b1 || c !== 12'h000) begin
            errors++; $display("FAIL pix_msd_seg_g: got hit %0b col %h want hit 1 col 000", h, c);
        end
        render(10'd48, 10'd145, h, c);
        checks++;
        if (h !== 1'b0 || c !== 12'h000) begin
            errors++; $display("FAIL pix_outside: got hit %0b col %h want hit 0 col 000", h, c);
        end
        render(10'd135, 10'd156, h, c);
        checks++;
        if (h !== 1'b1 || c !== 12'hFFF) begin
            errors++; $display("FAIL pix_lsd_seg_g: got hit %0b col %h want hit 1 col fff", h, c);
        end
    endtask

    task automatic test_tear();
        int          low;
        logic        h;
        logic [11:0] c;
        do_add(1, low);
        checks++;
        if (bus.score_bcd !== 16'h0009) begin
            errors++; $display("FAIL tear_score: got %h want 0009", bus.score_bcd);
        end
        render(10'd126, 10'd163, h, c);
        checks++;
        if (c !== 12'hFFF) begin
            errors++; $display("FAIL tear_old_frame: got col %h want fff", c);
        end
        frame_start();
        render(10'd126, 10'd163, h, c);
        checks++;
        if (h !== 1'b1 || c !== 12'h000) begin
            errors++; $display("FAIL tear_new_frame: got hit %0b col %h want hit 1 col 000", h, c);
        end
    endtask

    task automatic test_ce_hold();
        logic        h;
        logic [11:0] c;
        render(10'd135, 10'd156, h, c);
        bus.ce = 1'b0;
        bus.x  = 10'd48;
        bus.y  = 10'd145;
        repeat (3) tick();
        checks++;
        if (bus.pix_hit !== 1'b1 || bus.pix_colour !== 12'hFFF) begin
            errors++; $display("FAIL ce_hold: got hit %0b col %h want hit 1 col fff", bus.pix_hit, bus.pix_colour);
        end
    endtask

    task automatic test_lz();
        logic        h;
        logic [11:0] c;
        build_score(42);
        frame_start();
        render(10'd60, 10'd145, h, c);
        checks++;
        if (h !== 1'b1 || c !== LZ_COL) begin
            errors++; $display("FAIL lz_pos0: got hit %0b col %h want hit 1 col %h", h, c, LZ_COL);
        end
        render(10'd85, 10'd145, h, c);
        checks++;
        if (h !== 1'b1 || c !== LZ_COL) begin
            errors++; $display("FAIL lz_pos1: got hit %0b col %h want hit 1 col %h", h, c, LZ_COL);
        end
        render(10'd110, 10'd156, h, c);
        checks++;
        if (h !== 1'b1 || c !== 12'hFFF) begin
            errors++; $display("FAIL lz_digit4_g: got hit %0b col %h want hit 1 col fff", h, c);
        end
    endtask

    task automatic test_eights();
        logic        h;
        logic [11:0] c;
        build_score(8888);
        checks++;
        if (bus.score_bcd !== 16'h8888) begin
            errors++; $display("FAIL eights_score: got %h want 8888", bus.score_bcd);
        end
        frame_start();
        render(10'd60, 10'd156, h, c);
        checks++;
        if (h !== 1'b1 || c !== 12'hFFF) begin
            errors++; $display("FAIL eights_msd_g: got hit %0b col %h want hit 1 col fff", h, c);
        end
    endtask

    task automatic test_reset_mid_count();
        clear_score();
        bus.add_valid = 1'b1;
        bus.add_pts   = 8'd100;
        tick();
        bus.add_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (bus.pix_hit !== 1'b0 || bus.pix_colour !== 12'h000) begin
            errors++; $display("FAIL rst_pix: got hit %0b col %h want hit 0 col 000", bus.pix_hit, bus.pix_colour);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.score_bcd !== 16'h0000 || bus.add_ready !== 1'b1) begin
            errors++; $display("FAIL rst_abort: got %h ready %0b want 0000 ready 1", bus.score_bcd, bus.add_ready);
        end
        repeat (110) tick();
        checks++;
        if (bus.score_bcd !== 16'h0000) begin
            errors++; $display("FAIL rst_no_resume: got %h want 0000", bus.score_bcd);
        end
    endtask

    initial begin
        test_reset();
        test_add37();
        test_saturate();
        test_clear();
        test_pixels();
        test_tear();
        test_ce_hold();
        test_lz();
        test_eights();
        test_reset_mid_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
